echo_effect: RTL

ECHO_EFFECT -- requirements
Module: echo_effect

---
 rtl/echo_pkg.sv | 48 ++++
 rtl/echo_ram.sv | 36 +++
 rtl/echo_effect.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// -----------------------------------------------------------------------------
// echo_pkg
// Shared definitions for the echo effect: default sample and buffer widths,
// the sequencing state enumeration, the delay_sel -> delay length lookup and
// the saturation limits used when the dry and delayed samples are mixed.
// No ports (package).
// -----------------------------------------------------------------------------
package echo_pkg;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MIX   = 3'd2,
        ST_WRITE = 3'd3,
        ST_OUT   = 3'd4
    } echo_state_t;

    localparam int unsigned DLY_LEN_0 = 512;
    localparam int unsigned DLY_LEN_1 = 1024;
    localparam int unsigned DLY_LEN_2 = 2048;
    localparam int unsigned DLY_LEN_3 = 4095;

    function automatic int sat_hi(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int width);
        return -(1 << (width - 1));
    endfunction

    localparam int SAT_MAX = sat_hi(DATA_W);
    localparam int SAT_MIN = sat_lo(DATA_W);

    function automatic int unsigned delay_len(input logic [1:0] sel);
        int unsigned len;
        case (sel)
            2'd0:    len = DLY_LEN_0;
            2'd1:    len = DLY_LEN_1;
            2'd2:    len = DLY_LEN_2;
            default: len = DLY_LEN_3;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/echo_ram.sv
// -----------------------------------------------------------------------------
// echo_ram
// Single-port synchronous delay buffer, 2^ADDR_W x DATA_W. Read data appears
// one clock after the address is presented. Contents are never reset; the
// controller guards against reading locations not yet written.
// Ports:
//   i_clk    system clock
//   i_we     write enable (write i_wdata at i_addr on this edge)
//   i_addr   shared read/write address
//   i_wdata  write data
//   o_rdata  registered read data (old contents on a write cycle)
// -----------------------------------------------------------------------------
module echo_ram #(
    parameter int DATA_W = echo_pkg::DATA_W,
    parameter int ADDR_W = echo_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/echo_effect.sv
// -----------------------------------------------------------------------------
// echo_effect
// Sample-by-sample echo: each accepted sample is mixed with an attenuated copy
// of the sample written delay_sel-dependent samples earlier, saturated to the
// sample range, and presented a fixed 5 clocks after the accepting edge.
//
// Build option: define ECHO_FEEDBACK_EN to write the mixed result back into
// the delay buffer (decaying repeats); otherwise the dry input is stored and
// a single echo is produced.
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   datos_in   signed input sample
//   ready_in   one-cycle strobe, datos_in valid
//   enable     1 = echo mixed in, 0 = dry bypass
//   delay_sel  0=512, 1=1024, 2=2048, 3=4095 samples
//   datos_out  processed sample, held between strobes
//   valid_out  one-cycle strobe, datos_out updated
//   busy       state machine outside IDLE
//   overrun    one-cycle pulse, a strobe was dropped while busy
//
// state | meaning
// IDLE  | waiting for ready_in; captures sample, enable and delay
// READ  | delay buffer addressed at wr_ptr - delay
// MIX   | buffer data valid; mix, saturate and register result
// WRITE | buffer written at wr_ptr; wr_ptr and fill_count advance
// OUT   | result handed to the output register
// -----------------------------------------------------------------------------
module echo_effect #(
    parameter int DATA_W      = echo_pkg::DATA_W,
    parameter int ADDR_W      = echo_pkg::ADDR_W,
    parameter int ATTEN_SHIFT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] datos_in,
    input  logic              ready_in,
    input  logic              enable,
    input  logic [1:0]        delay_sel,
    output logic [DATA_W-1:0] datos_out,
    output logic              valid_out,
    output logic              busy,
    output logic              overrun
);

    import echo_pkg::*;

    localparam logic signed [DATA_W:0] L_SAT_HI = (DATA_W+1)'(sat_hi(DATA_W));
    localparam logic signed [DATA_W:0] L_SAT_LO = (DATA_W+1)'(sat_lo(DATA_W));

    echo_state_t r_state;
    echo_state_t w_state_nxt;

    logic w_capture;
    logic w_mix_ld;
    logic w_ram_we;
    logic w_out_ld;

    logic [DATA_W-1:0] r_in;
    logic              r_en;
    logic [ADDR_W-1:0] r_dly;
    logic [DATA_W-1:0] r_result;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_fill;
    logic              r_out_pend;
    logic [DATA_W-1:0] r_dout;
    logic              r_valid;
    logic              r_overrun;

    logic [ADDR_W-1:0]        w_rd_addr;
    logic [ADDR_W-1:0]        w_ram_addr;
    logic [DATA_W-1:0]        w_ram_rdata;
    logic [DATA_W-1:0]        w_ram_wdata;
    logic [DATA_W-1:0]        w_delayed;
    logic signed [DATA_W-1:0] w_atten;
    logic signed [DATA_W:0]   w_sum;
    logic [DATA_W-1:0]        w_mix;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-state controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_mix_ld    = 1'b0;
        w_ram_we    = 1'b0;
        w_out_ld    = 1'b0;
        w_ram_addr  = r_wr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (ready_in) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_ram_addr  = w_rd_addr;
                w_state_nxt = ST_MIX;
            end
            ST_MIX: begin
                w_mix_ld    = 1'b1;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                w_ram_we    = 1'b1;
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                w_out_ld    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Mix datapath
    // ------------------------------------------------------------------
    assign w_rd_addr = r_wr_ptr - r_dly;

    // Until delay samples have been written since reset the addressed
    // location holds stale or never-written data, so treat it as silence.
    assign w_delayed = (r_fill < r_dly) ? '0 : w_ram_rdata;
    assign w_atten   = $signed(w_delayed) >>> ATTEN_SHIFT;

    // One extra bit so the sum of two full-scale samples cannot wrap.
    assign w_sum = $signed({r_in[DATA_W-1], r_in}) + $signed({w_atten[DATA_W-1], w_atten});

    always_comb begin
        w_mix = w_sum[DATA_W-1:0];
        if (w_sum > L_SAT_HI) begin
            w_mix = L_SAT_HI[DATA_W-1:0];
        end else if (w_sum < L_SAT_LO) begin
            w_mix = L_SAT_LO[DATA_W-1:0];
        end
    end

`ifdef ECHO_FEEDBACK_EN
    // Recirculate the output value so each repeat is attenuated again.
    assign w_ram_wdata = r_result;
`else
    assign w_ram_wdata = r_in;
`endif

    // ------------------------------------------------------------------
    // Capture, pointers and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_in       <= '0;
            r_en       <= 1'b0;
            r_dly      <= '0;
            r_result   <= '0;
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_out_pend <= 1'b0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun  <= ready_in && (r_state != ST_IDLE);
            // OUT hands the result on; the output register updates one edge
            // later so valid_out lands exactly 5 edges after acceptance.
            r_out_pend <= w_out_ld;
            r_valid    <= r_out_pend;
            if (r_out_pend) begin
                r_dout <= r_result;
            end
            if (w_capture) begin
                r_in  <= datos_in;
                r_en  <= enable;
                r_dly <= ADDR_W'(delay_len(delay_sel));
            end
            if (w_mix_ld) begin
                r_result <= r_en ? w_mix : r_in;
            end
            if (w_ram_we) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                if (r_fill != '1) begin
                    r_fill <= r_fill + ADDR_W'(1);
                end
            end
        end
    end

    assign datos_out = r_dout;
    assign valid_out = r_valid;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Delay buffer
    // ------------------------------------------------------------------
    echo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

endmodule
